// File: rtl/imem_loader.sv
// Byte-stream loader for the 32-word instruction memory: parses a counted,
// XOR-checksummed frame, writes little-endian words and gates the CPU reset.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] n_last, n_last_nxt;
  logic [ADDR_W-1:0] widx, widx_nxt;
  logic [1:0]        bidx, bidx_nxt;
  logic [7:0]        chk, chk_nxt;
  logic [23:0]       asm_word, asm_word_nxt;

  logic              in_ready_nxt, mem_we_nxt, cpu_rst_n_nxt, done_nxt, error_nxt;
  logic [ADDR_W-1:0] mem_waddr_nxt;
  logic [31:0]       mem_wdata_nxt;

  logic accept;
  logic count_bad;
  logic last_byte;

  assign accept    = in_valid & in_ready;
  assign count_bad = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign last_byte = (bidx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_COUNT;
      S_COUNT: if (accept) state_nxt = count_bad ? S_ERR : S_DATA;
      S_DATA:  if (accept && last_byte && (widx == n_last)) state_nxt = S_CHECK;
      S_CHECK: if (accept) state_nxt = (in_data == chk) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    n_last_nxt    = n_last;
    widx_nxt      = widx;
    bidx_nxt      = bidx;
    chk_nxt       = chk;
    asm_word_nxt  = asm_word;
    mem_we_nxt    = 1'b0;
    mem_waddr_nxt = mem_waddr;
    mem_wdata_nxt = mem_wdata;
    cpu_rst_n_nxt = cpu_rst_n;
    done_nxt      = done;
    error_nxt     = error;
    in_ready_nxt  = (state_nxt == S_COUNT) || (state_nxt == S_DATA) || (state_nxt == S_CHECK);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_nxt      = 1'b0;
          error_nxt     = 1'b0;
          cpu_rst_n_nxt = 1'b0;
          widx_nxt      = '0;
          bidx_nxt      = '0;
          chk_nxt       = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (count_bad) begin
            error_nxt = 1'b1;
          end else begin
            n_last_nxt = ADDR_W'(in_data - 8'd1);
            chk_nxt    = in_data;
            widx_nxt   = '0;
            bidx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_nxt = chk ^ in_data;
          if (last_byte) begin
            mem_we_nxt    = 1'b1;
            mem_waddr_nxt = widx;
            mem_wdata_nxt = {in_data, asm_word};
            bidx_nxt      = '0;
            if (widx != n_last) widx_nxt = widx + ADDR_W'(1);
          end else begin
            case (bidx)
              2'd0:    asm_word_nxt[7:0]   = in_data;
              2'd1:    asm_word_nxt[15:8]  = in_data;
              default: asm_word_nxt[23:16] = in_data;
            endcase
            bidx_nxt = bidx + 2'd1;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (in_data == chk) begin
            done_nxt      = 1'b1;
            cpu_rst_n_nxt = 1'b1;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_last    <= '0;
      widx      <= '0;
      bidx      <= '0;
      chk       <= '0;
      asm_word  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      n_last    <= n_last_nxt;
      widx      <= widx_nxt;
      bidx      <= bidx_nxt;
      chk       <= chk_nxt;
      asm_word  <= asm_word_nxt;
      in_ready  <= in_ready_nxt;
      mem_we    <= mem_we_nxt;
      mem_waddr <= mem_waddr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rst_n <= cpu_rst_n_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked
// against a frame-level model of the loader.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_rst_n, done, error;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        frame[$];
  logic [ADDR_W+31:0] wr_q[$];
  logic [ADDR_W+31:0] exp_wr[$];
  bit exp_done, exp_err;

  localparam logic [ADDR_W+31:0] GOOD_W0 = {5'd0, 32'h00500113};
  localparam logic [ADDR_W+31:0] GOOD_W1 = {5'd1, 32'h00210233};

  always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back({mem_waddr, mem_wdata});

  // Frame-level reference: parse count, build little-endian words, XOR checksum.
  function automatic void build_expect();
    int n;
    logic [7:0] x;
    exp_wr.delete();
    n = int'(frame[0]);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (n == 0 || n > DEPTH) return;
    x = frame[0];
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back({ADDR_W'(k), frame[4*k+4], frame[4*k+3], frame[4*k+2], frame[4*k+1]});
      x = x ^ frame[4*k+1] ^ frame[4*k+2] ^ frame[4*k+3] ^ frame[4*k+4];
    end
    exp_done = (frame[4*n+1] == x);
    exp_err  = !exp_done;
  endfunction

  task automatic send_frame(input int gap_pct, input int start_at);
    bit acc;
    int guard;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < frame.size(); i++) begin
      guard = 0;
      do begin
        @(negedge clk);
        start    = (i == start_at);
        in_data  = frame[i];
        in_valid = ($urandom_range(0, 99) >= gap_pct);
        acc      = in_valid && in_ready;
        @(posedge clk);
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout byte %0d: in_ready=%b required 1", i, in_ready);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'h02; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, done, error, cpu_rst_n} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/we/done/err/cpurst=%b required 00000",
               {in_ready, mem_we, done, error, cpu_rst_n});
    end
    checks++;
    if (mem_waddr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h required 0/0", mem_waddr, mem_wdata);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b done=%b error=%b required 0 0 0", in_ready, done, error);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_good_load(input int gap_pct, input int start_at, input string tag);
    frame = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00, 8'h50};
    wr_q.delete();
    send_frame(gap_pct, start_at);
    checks++;
    if ({done, cpu_rst_n, error, in_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_status: done/cpurst/err/rdy=%b required 1100", tag, {done, cpu_rst_n, error, in_ready});
    end
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL %s_wcount: writes=%0d required 2", tag, wr_q.size());
    end else if (wr_q[0] !== GOOD_W0 || wr_q[1] !== GOOD_W1) begin
      errors++;
      $display("FAIL %s_words: got %h,%h required %h,%h", tag, wr_q[0], wr_q[1], GOOD_W0, GOOD_W1);
    end
  endtask

  task automatic test_bad_checksum();
    frame = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00, 8'h51};
    wr_q.delete();
    send_frame(0, -1);
    checks++;
    if ({error, done, cpu_rst_n, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL badchk_status: err/done/cpurst/rdy=%b required 1000", {error, done, cpu_rst_n, in_ready});
    end
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== GOOD_W0 || wr_q[1] !== GOOD_W1) begin
      errors++;
      $display("FAIL badchk_words: %0d writes, required 2 good words kept", wr_q.size());
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks++;
    if ({error, in_ready, cpu_rst_n} !== 3'b010) begin
      errors++;
      $display("FAIL restart_clears: err/rdy/cpurst=%b required 010", {error, in_ready, cpu_rst_n});
    end
  endtask

  task automatic test_illegal_count();
    frame = '{8'h00};
    wr_q.delete();
    send_frame(0, -1);
    checks++;
    if ({error, in_ready, done} !== 3'b100) begin
      errors++;
      $display("FAIL count0: err/rdy/done=%b required 100", {error, in_ready, done});
    end
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_holds: error=%b in_ready=%b required 1 0", error, in_ready);
    end
    frame = '{8'h21};
    send_frame(0, -1);
    checks++;
    if ({error, in_ready, done, cpu_rst_n} !== 4'b1000) begin
      errors++;
      $display("FAIL count33: err/rdy/done/cpurst=%b required 1000", {error, in_ready, done, cpu_rst_n});
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_nowrite: writes=%0d required 0", wr_q.size());
    end
  endtask

  task automatic test_reset_mid_data();
    frame = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02};
    wr_q.delete();
    send_frame(0, -1);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h21;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, done, error, cpu_rst_n} !== 5'b0 || mem_waddr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy/we/done/err/cpurst=%b addr=%h data=%h required all 0",
               {in_ready, mem_we, done, error, cpu_rst_n}, mem_waddr, mem_wdata);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== GOOD_W0) begin
      errors++;
      $display("FAIL midreset_writes: %0d writes, required only %h", wr_q.size(), GOOD_W0);
    end
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_good_load(0, -1, "after_reset");
  endtask

  task automatic test_random();
    int sel, n;
    logic [7:0] b, x;
    for (int it = 0; it < 16; it++) begin
      frame.delete();
      sel = (it == 0) ? 2 : $urandom_range(0, 9);
      if (sel == 0) frame.push_back(8'h00);
      else if (sel == 1) frame.push_back(8'($urandom_range(DEPTH + 1, 255)));
      else begin
        n = (sel == 2) ? DEPTH : $urandom_range(1, 8);
        frame.push_back(8'(n));
        x = 8'(n);
        repeat (4 * n) begin
          b = 8'($urandom);
          frame.push_back(b);
          x ^= b;
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        frame.push_back(x);
      end
      build_expect();
      wr_q.delete();
      send_frame($urandom_range(0, 50), -1);
      checks++;
      if (done !== exp_done || error !== exp_err || cpu_rst_n !== exp_done || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_status: done=%b err=%b cpurst=%b rdy=%b required %b %b %b 0",
                 it, done, error, cpu_rst_n, in_ready, exp_done, exp_err, exp_done);
      end
      checks++;
      if (wr_q.size() != exp_wr.size()) begin
        errors++;
        $display("FAIL rand%0d_wcount: writes=%0d required %0d", it, wr_q.size(), exp_wr.size());
      end else begin
        for (int k = 0; k < exp_wr.size(); k++) begin
          if (wr_q[k] !== exp_wr[k]) begin
            errors++;
            $display("FAIL rand%0d_word%0d: got %h required %h", it, k, wr_q[k], exp_wr[k]);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_good_load(0, -1, "good");
    test_bad_checksum();
    test_illegal_count();
    test_good_load(40, 3, "backpressure");
    test_reset_mid_data();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the processor's 32-word instruction memory. It is the write side of the instruction memory that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word to consecutive word addresses and verifies a trailing XOR checksum. While loading, it holds the processor in reset and releases it only after a verified load.

## Interface

- DEPTH, 32, instruction memory size in words; legal word counts are 1..DEPTH
- ADDR_W, 5, word-address width; DEPTH ≤ 2^ADDR_W
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  load request; sampled every cycle
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_waddr  output  ADDR_W  word address (memory index = byte PC >> 2)
- mem_wdata  output  32  word to write
- cpu_rst_n  output  1  processor reset, active-low; drives the processor's rst
- done  output  1  verified load complete (level)
- error  output  1  load aborted or checksum mismatch (level)

## Operation

- Frame format: count byte N, then 4·N payload bytes (byte 0 = bits 7:0 of word 0), then one checksum byte.
- Checksum = XOR of N and all payload bytes.
- A byte transfers on a rising edge where in_valid && in_ready. in_data must hold while in_valid=1 and the byte is unaccepted.
- FSM states and transitions:
  - IDLE: in_ready=0. start → COUNT.
  - COUNT: in_ready=1. On accept:
    - N==0 or N>DEPTH → ERR.
    - Otherwise latch N, chk=N, word index=0, byte index=0 → DATA.
  - DATA: in_ready=1. Each accepted byte is shifted into a 32-bit assembly register at lane byte index, and chk ^= byte.
    - On the 4th byte, register mem_wdata, mem_waddr=word index, and mem_we=1 for the next cycle.
    - Then word index+1 and byte index=0.
    - After word N-1 is assembled → CHECK.
  - CHECK: in_ready=1. On accept, byte==chk → DONE, else ERR.
  - DONE: done=1, cpu_rst_n=1, in_ready=0.
  - ERR: error=1, cpu_rst_n=0, in_ready=0.
- start is honoured only in IDLE, DONE and ERR; it is ignored in COUNT, DATA and CHECK. Accepting start:
  - clears done and error
  - drives cpu_rst_n=0
  - clears the word index, byte index and chk
  - enters COUNT
- Words written before an error remain in memory. No rollback.
- Byte and word indices are sized to cover DEPTH exactly. Word index never exceeds N-1, so there is no wrap-around.

## Timing

- Reset values (rst=0 at an edge):
  - state IDLE
  - in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0
  - cpu_rst_n=0, done=0, error=0
  - indices and chk=0
- Reset mid-load aborts immediately. mem_we is 0 from the next edge; any word whose 4th byte was not yet accepted is never written.
- All outputs are registered. in_ready reflects the current state.
- Throughput is one byte per cycle. in_ready stays 1 during the mem_we cycle, so back-to-back streaming never stalls.
- Latency:
  - The 4th byte accepted at edge k gives mem_we=1 during cycle k..k+1.
  - The checksum accepted at edge k gives done/cpu_rst_n=1 (or error=1) after edge k.
- Minimum load duration is 1 (start) + 1 + 4N + 1 cycles.
- in_ready=0 in the cycle after leaving CHECK/COUNT. A byte presented then is not consumed.
- start and a byte in the same cycle in DONE/ERR: only start acts. The byte is not accepted because in_ready=0.

## Test plan

- Reset: hold rst=0 for 2 cycles with in_valid=1 → in_ready=0, mem_we=0, done=0, error=0, cpu_rst_n=0. State stays IDLE without start.
- Good load: start, then bytes 02,13,01,50,00,33,02,21,00,50 with no gaps → expect:
  - mem_we pulses with (addr 0, 0x00500113) then (addr 1, 0x00210233)
  - done=1 and cpu_rst_n=1 one cycle after the checksum 50 is accepted
- Bad checksum: same frame with last byte 51 → both words written, error=1, done=0, cpu_rst_n=0. A new start clears error.
- Illegal count: N=00, then separately N=21 (33 > DEPTH) → error=1 after the count byte, no mem_we, and in_ready=0 afterwards.
- Backpressure and gaps: the good-load frame with in_valid toggling 1/0 and a start pulse mid-DATA → identical writes and done. The start pulse has no effect.
- Reset mid-DATA: rst=0 after 6 payload bytes → only addr 0 written, IDLE, all outputs at reset values. A subsequent full good load succeeds.
